// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined RV32I immediate generator.
// The imm_gen_pipe_if interface and the imm_gen_decode/imm_gen_pipe modules all import this package.

package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OpcLoad     = 7'b0000011;
  localparam logic [6:0] OpcOpImm    = 7'b0010011;
  localparam logic [6:0] OpcOpImm32  = 7'b0011011;
  localparam logic [6:0] OpcAuipc    = 7'b0010111;
  localparam logic [6:0] OpcStore    = 7'b0100011;
  localparam logic [6:0] OpcLui      = 7'b0110111;
  localparam logic [6:0] OpcBranch   = 7'b1100011;
  localparam logic [6:0] OpcJalr     = 7'b1100111;
  localparam logic [6:0] OpcJal      = 7'b1101111;
  localparam logic [6:0] OpcSystem   = 7'b1110011;

  // Entry layout at the widest legal configuration; the pipe keeps a width-exact copy.
  localparam int unsigned MaxXlen = 64;
  localparam int unsigned MaxTagW = 16;

  typedef struct packed {
    logic [MaxXlen-1:0] imm;
    imm_fmt_e           fmt;
    logic [MaxTagW-1:0] tag;
  } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-to-execute stream bundle: instruction in, decoded immediate out, each with valid/ready.

interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) ();
  import imm_gen_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  imm_fmt_e         out_fmt;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag
  );

endinterface

// File: rtl/imm_gen_decode.sv
// Combinational RV32I immediate decoder: instr -> sign-extended imm and format code.
// Define IMM_GEN_ZICSR_EN to decode CSR*I uimm fields as FMT_Z.

module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [20:0] imm_j;

  assign imm_i = instr[31:20];
  assign imm_s = {instr[31:25], instr[11:7]};
  assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    unique case (instr[6:0])
      OpcLoad, OpcOpImm, OpcJalr: begin
        fmt = FMT_I;
        imm = XLEN'(imm_i);
      end
      OpcSystem: begin
`ifdef IMM_GEN_ZICSR_EN
        if (instr[14]) begin
          fmt = FMT_Z;
          imm = XLEN'(instr[19:15]);
        end else begin
          fmt = FMT_I;
          imm = XLEN'(imm_i);
        end
`else
        fmt = FMT_I;
        imm = XLEN'(imm_i);
`endif
      end
      OpcOpImm32: begin
        // *W immediates only exist on RV64.
        if (XLEN == 64) begin
          fmt = FMT_I;
          imm = XLEN'(imm_i);
        end
      end
      OpcStore: begin
        fmt = FMT_S;
        imm = XLEN'(imm_s);
      end
      OpcBranch: begin
        fmt = FMT_B;
        imm = XLEN'(imm_b);
      end
      OpcLui, OpcAuipc: begin
        fmt = FMT_U;
        imm = XLEN'(imm_u);
      end
      OpcJal: begin
        fmt = FMT_J;
        imm = XLEN'(imm_j);
      end
      default: begin
        fmt = FMT_NONE;
        imm = '0;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator stage: decode, registered output and one-entry skid for full throughput.
// Optional CSR*I decoding is enabled by IMM_GEN_ZICSR_EN (see imm_gen_decode).

module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    imm_fmt_e         fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  localparam entry_t EntryReset = '{imm: '0, fmt: FMT_NONE, tag: '0};

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  entry_t          dec_entry;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;

  logic in_ready;
  logic in_fire;
  logic out_drain;

  imm_gen_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr(bus.in_instr),
    .imm  (dec_imm),
    .fmt  (dec_fmt)
  );

  assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, tag: bus.in_tag};

  // in_ready depends only on state (and rst), never on out_ready.
  assign in_ready  = ~skid_valid_q & ~rst;
  assign in_fire   = bus.in_valid & in_ready & ~flush;
  assign out_drain = out_valid_q & bus.out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_drain) begin
      // Skid holds the older entry, so it wins; in_ready was low if it is full.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= EntryReset;
      out_valid_q  <= 1'b0;
      skid_q       <= EntryReset;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_q.imm;
  assign bus.out_fmt   = out_q.fmt;
  assign bus.out_tag   = out_q.tag;

endmodule
